// File: rtl/fb_addr_if.sv
// fb_addr_if: request/response handshake bundle between a pixel producer and fb_addr_pipe.
interface fb_addr_if #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_BITS = 20
);
    localparam int FB_X_BITS = $clog2(FB_WIDTH);
    localparam int FB_Y_BITS = $clog2(FB_HEIGHT);
    logic                 in_valid;
    logic                 in_ready;
    logic [FB_X_BITS-1:0] in_x;
    logic [FB_Y_BITS-1:0] in_y;
    logic [ADDR_BITS-1:0] in_base;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_BITS-1:0] out_addr;
    logic                 out_oob;
    modport master (
        output in_valid, in_x, in_y, in_base, out_ready,
        input  in_ready, out_valid, out_addr, out_oob
    );
    modport slave (
        input  in_valid, in_x, in_y, in_base, out_ready,
        output in_ready, out_valid, out_addr, out_oob
    );
endinterface

// File: rtl/fb_addr_pipe.sv
// fb_addr_pipe: two-stage pipelined framebuffer address generator, addr = base + y*FB_WIDTH + x.
// Define FB_ADDR_PIPE_CLIP_EN to drop out-of-bounds requests at S1 instead of flagging them.
module fb_addr_pipe #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_BITS = 20
) (
    input logic      clk,
    input logic      reset,
    fb_addr_if.slave bus
);
    localparam int XB = $clog2(FB_WIDTH);
    localparam int YB = $clog2(FB_HEIGHT);
    localparam int PB = YB + $clog2(FB_WIDTH + 1);
    localparam logic [XB:0]   X_LIM = FB_WIDTH[XB:0];
    localparam logic [YB:0]   Y_LIM = FB_HEIGHT[YB:0];
    localparam logic [PB-1:0] W_MUL = PB'(FB_WIDTH);

    logic                 advance;
    logic                 in_oob;
    logic                 s1_valid;
    logic [PB-1:0]        s1_prod;
    logic [XB-1:0]        s1_x;
    logic [ADDR_BITS-1:0] s1_base;
    logic [ADDR_BITS-1:0] sum;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;
    assign in_oob       = ({1'b0, bus.in_x} >= X_LIM) || ({1'b0, bus.in_y} >= Y_LIM);
    assign sum          = s1_base + ADDR_BITS'(s1_prod) + ADDR_BITS'(s1_x);

`ifdef FB_ADDR_PIPE_CLIP_EN
    assign bus.out_oob = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
        end else if (advance) begin
            s1_valid      <= bus.in_valid && !in_oob;
            s1_prod       <= PB'(bus.in_y) * W_MUL;
            s1_x          <= bus.in_x;
            s1_base       <= bus.in_base;
            bus.out_valid <= s1_valid;
            bus.out_addr  <= sum;
        end
    end
`else
    logic s1_oob;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_oob   <= 1'b0;
        end else if (advance) begin
            s1_valid      <= bus.in_valid;
            s1_prod       <= PB'(bus.in_y) * W_MUL;
            s1_x          <= bus.in_x;
            s1_base       <= bus.in_base;
            s1_oob        <= in_oob;
            bus.out_valid <= s1_valid;
            bus.out_addr  <= sum;
            bus.out_oob   <= s1_oob;
        end
    end
`endif
endmodule

// File: doc/fb_addr_pipe.md
Name: fb_addr_pipe

Overview:
- Pipelined framebuffer address generator: maps (x, y) pixel coordinates plus a per-request base address to a linear memory address: addr = base + y*FB_WIDTH + x.
- Valid/ready on input and output, so it can sit between a pixel producer (line drawer, blitter, display fetch) and the SRAM arbiter.
- Flags or drops out-of-bounds coordinates; the base input supports double/multi-buffering.

Parameters:
- FB_WIDTH, 640 (VGA mode horizontal visible): pixels per line; multiplier constant.
- FB_HEIGHT, 480 (VGA mode vertical visible): lines per frame; bound for the y check.
- ADDR_BITS, 20: output address width; all address arithmetic is modulo 2^ADDR_BITS.
- Derived: FB_X_BITS = $clog2(FB_WIDTH), FB_Y_BITS = $clog2(FB_HEIGHT).

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block accepts request this cycle
- in_x  in  FB_X_BITS  pixel column
- in_y  in  FB_Y_BITS  pixel row
- in_base  in  ADDR_BITS  buffer base address, sampled with x/y
- out_valid  out  1  address valid
- out_ready  in  1  downstream accepts address
- out_addr  out  ADDR_BITS  linear address
- out_oob  out  1  request was out of bounds (x >= FB_WIDTH or y >= FB_HEIGHT)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Pipeline: two register stages.
  - S1 registers y*FB_WIDTH (full product width), x, base, and the oob flag.
  - S2 registers base + product + x, truncated to ADDR_BITS, plus oob.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stall rule: advance = !out_valid || out_ready. When advance is low, both stages hold their contents. in_ready = advance, combinational from out_ready and the S2 valid.
- Bubbles: an empty S1 may not be filled by a held stage; bubbles are allowed to persist under stall. No request is ever lost or duplicated.
- Output stability: while out_valid && !out_ready, out_addr and out_oob are held stable.
- Arithmetic: the product is computed at full width, then the sum is truncated to ADDR_BITS, so it wraps silently (no saturation, no error flag). The oob test is an unsigned compare on the raw inputs; y >= FB_HEIGHT is possible whenever FB_HEIGHT is not a power of two, and likewise for x.
- Reset values: S1/S2 valid = 0, out_valid = 0, out_addr = 0, out_oob = 0. in_ready is 1 on the first cycle after reset deasserts. Reset mid-stream discards all in-flight requests; no partial output appears.
- Simultaneous events: an input and an output transfer in the same cycle are legal and keep full throughput. in_x/in_y/in_base are ignored when in_valid = 0.
- No state machine beyond the valid pipeline. The multiply must be a single registered stage so it infers a DSP or shift-add with no combinational path from input to output.

Optional Feature:
- Macro: FB_ADDR_PIPE_CLIP_EN.
- Defined:
  - Out-of-bounds requests are accepted (in_ready unaffected) but dropped at S1: the valid bit is cleared, nothing is emitted, and the slot becomes a bubble.
  - out_oob is constant 0.
- Undefined (default):
  - Every accepted request produces exactly one output, in order.
  - Out-of-bounds requests emit the computed address (which may alias other pixels) with out_oob = 1.

Test Plan (FB_WIDTH=640, FB_HEIGHT=480, ADDR_BITS=20):
- Basic: (x=0, y=0, base=0) -> out_valid 2 cycles later, addr=0, oob=0. Then (639, 479, 0) -> addr=307199, oob=0.
- Base/double-buffer: (1, 1, base=307200) -> addr=307841. Then (5, 0, base=0xFFFFF) -> addr=0x00004 (wrap).
- Streaming: 8 back-to-back requests (x=0..7, y=2), out_ready=1 -> 8 consecutive outputs 1280..1287, with in_ready held at 1 throughout.
- Backpressure:
  - 3 requests while out_ready=0 -> in_ready drops after the pipe fills; out_addr stays stable.
  - Release out_ready -> all outputs emerge in order, none lost or duplicated.
  - Checked against a scoreboard over 1000 random valid/ready cycles.
- OOB:
  - (640, 0, 0) and (0, 480, 0) without the macro -> addrs 640 and 307200, each with oob=1.
  - With FB_ADDR_PIPE_CLIP_EN -> neither emitted; the neighbouring in-bounds request still emitted, in order.
- Reset mid-operation: assert reset with both stages full and out_ready=0 -> the cycle after release shows out_valid=0 and in_ready=1, and the discarded requests never appear.
